// File: rtl/conv_stream_tx.sv
// rtl/conv_stream_tx.sv - transmit sequencer feeding filter/image beats to the convolution engine
module conv_stream_tx #(
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       cfg_filter_size,
  input  logic [3:0] cfg_image_size,
  input  logic       cfg_pad_mode,
  input  logic       cfg_act_mode,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic       err,
  output logic [6:0] result_cnt,
  output logic       filter_valid,
  output logic       image_valid,
  output logic       filter_size,
  output logic [3:0] image_size,
  output logic       pad_mode,
  output logic       act_mode,
  output logic [7:0] in_data,
  input  logic       conv_out_valid
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]    GAP_LAST  = 7'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, SEND_FILT, GAP, SEND_IMG, WAIT_RES, COLLECT, DONE} state_e;

  state_e        state_q, state_d;
  logic [6:0]    idx_q, idx_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [6:0]    cnt_q, cnt_d;
  logic          cfg_fs_q, cfg_fs_d, cfg_pad_q, cfg_pad_d, cfg_act_q, cfg_act_d;
  logic [3:0]    cfg_is_q, cfg_is_d;
  logic          busy_q, busy_d, done_q, done_d, timeout_q, timeout_d, err_q, err_d;
  logic          fv_q, fv_d, iv_q, iv_d, fs_q, fs_d, pad_q, pad_d, act_q, act_d;
  logic [3:0]    is_q, is_d;
  logic [7:0]    data_q, data_d;

  logic [7:0] filt_q [25];
  logic [7:0] img_q  [64];

  logic       we_f, we_i, size_ok;
  logic [6:0] filt_last, img_len, img_last;
  logic [7:0] rd_f, rd_i;

  // Host writes are blocked for the whole transfer so the engine sees a stable snapshot.
  assign we_f      = wr_en & ~busy_q & ~wr_sel & (wr_addr < 7'd25);
  assign we_i      = wr_en & ~busy_q &  wr_sel & (wr_addr < 7'd64);
  assign size_ok   = (cfg_image_size >= 4'd4) && (cfg_image_size <= 4'd8);
  assign filt_last = cfg_fs_q ? 7'd24 : 7'd8;
  assign img_len   = 7'({3'b000, cfg_is_q} * {3'b000, cfg_is_q});
  assign img_last  = img_len - 7'd1;

  // Sample buffers; intentionally not reset so contents survive an aborted transfer.
  always_ff @(posedge clk) begin
    if (we_f) filt_q[wr_addr[4:0]] <= wr_data;
    if (we_i) img_q[wr_addr[5:0]]  <= wr_data;
  end

  // Next-state logic; outputs are derived from the next state so they register in step with it.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    cfg_fs_d  = cfg_fs_q;
    cfg_is_d  = cfg_is_q;
    cfg_pad_d = cfg_pad_q;
    cfg_act_d = cfg_act_q;
    timeout_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (size_ok) begin
            cfg_fs_d  = cfg_filter_size;
            cfg_is_d  = cfg_image_size;
            cfg_pad_d = cfg_pad_mode;
            cfg_act_d = cfg_act_mode;
            cnt_d     = 7'd0;
            idx_d     = 7'd0;
            state_d   = SEND_FILT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND_FILT: begin
        if (idx_q == filt_last) begin
          idx_d   = 7'd0;
          state_d = (GAP_CYCLES == 0) ? SEND_IMG : GAP;
        end else begin
          idx_d = idx_q + 7'd1;
        end
      end
      GAP: begin
        if (idx_q == GAP_LAST) begin
          idx_d   = 7'd0;
          state_d = SEND_IMG;
        end else begin
          idx_d = idx_q + 7'd1;
        end
      end
      SEND_IMG: begin
        if (idx_q == img_last) begin
          idx_d   = 7'd0;
          wait_d  = '0;
          state_d = WAIT_RES;
        end else begin
          idx_d = idx_q + 7'd1;
        end
      end
      WAIT_RES: begin
        if (conv_out_valid) begin
          cnt_d   = 7'd1;
          state_d = COLLECT;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      COLLECT: begin
        if (conv_out_valid) begin
          if (cnt_q != 7'd127) cnt_d = cnt_q + 7'd1;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A write landing on the same edge as the first read is forwarded.
    rd_f = (we_f && (wr_addr[4:0] == idx_d[4:0])) ? wr_data : filt_q[idx_d[4:0]];
    rd_i = (we_i && (wr_addr[5:0] == idx_d[5:0])) ? wr_data : img_q[idx_d[5:0]];

    fv_d   = (state_d == SEND_FILT);
    iv_d   = (state_d == SEND_IMG);
    fs_d   = fv_d & cfg_fs_d;
    pad_d  = fv_d & cfg_pad_d;
    act_d  = fv_d & cfg_act_d;
    is_d   = iv_d ? cfg_is_d : 4'd0;
    data_d = fv_d ? rd_f : (iv_d ? rd_i : 8'd0);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, counters, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 7'd0;
      wait_q    <= '0;
      cnt_q     <= 7'd0;
      cfg_fs_q  <= 1'b0;
      cfg_is_q  <= 4'd0;
      cfg_pad_q <= 1'b0;
      cfg_act_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      fv_q      <= 1'b0;
      iv_q      <= 1'b0;
      fs_q      <= 1'b0;
      pad_q     <= 1'b0;
      act_q     <= 1'b0;
      is_q      <= 4'd0;
      data_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      cfg_fs_q  <= cfg_fs_d;
      cfg_is_q  <= cfg_is_d;
      cfg_pad_q <= cfg_pad_d;
      cfg_act_q <= cfg_act_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      fv_q      <= fv_d;
      iv_q      <= iv_d;
      fs_q      <= fs_d;
      pad_q     <= pad_d;
      act_q     <= act_d;
      is_q      <= is_d;
      data_q    <= data_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign err          = err_q;
  assign result_cnt   = cnt_q;
  assign filter_valid = fv_q;
  assign image_valid  = iv_q;
  assign filter_size  = fs_q;
  assign image_size   = is_q;
  assign pad_mode     = pad_q;
  assign act_mode     = act_q;
  assign in_data      = data_q;

endmodule

// File: tb/tb_conv_stream_tx.sv
// tb/tb_conv_stream_tx.sv - directed self-checking bench for conv_stream_tx
module tb_conv_stream_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, wr_sel, start;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       cfg_filter_size, cfg_pad_mode, cfg_act_mode;
  logic [3:0] cfg_image_size;
  logic       busy, done, timeout, err;
  logic [6:0] result_cnt;
  logic       filter_valid, image_valid, filter_size, pad_mode, act_mode;
  logic [3:0] image_size;
  logic [7:0] in_data;
  logic       conv_out_valid;

  conv_stream_tx #(.GAP_CYCLES(1), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .cfg_filter_size(cfg_filter_size),
    .cfg_image_size(cfg_image_size), .cfg_pad_mode(cfg_pad_mode), .cfg_act_mode(cfg_act_mode),
    .busy(busy), .done(done), .timeout(timeout), .err(err), .result_cnt(result_cnt),
    .filter_valid(filter_valid), .image_valid(image_valid), .filter_size(filter_size),
    .image_size(image_size), .pad_mode(pad_mode), .act_mode(act_mode), .in_data(in_data),
    .conv_out_valid(conv_out_valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] fmod [25];
  logic [7:0] imod [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_buf(input logic sel, input int addr, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 7'(addr); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Runs start + filter + gap + image beats, checking every beat; returns in the first WAIT_RES cycle.
  task automatic xfer(input logic fs, input logic [3:0] s, input logic pad, input logic act,
                      input bit noisy, input bit wr_busy, input int abort_at,
                      input bit same_wr, input logic [7:0] same_val);
    int nf, ni;
    nf = fs ? 25 : 9;
    ni = s * s;
    cfg_filter_size = fs; cfg_image_size = s; cfg_pad_mode = pad; cfg_act_mode = act;
    start = 1'b1;
    if (same_wr) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 7'd0; wr_data = same_val;
      fmod[0] = same_val;
    end
    step();
    start = 1'b0; wr_en = 1'b0;
    conv_out_valid = noisy;
    for (int k = 0; k < nf; k++) begin
      check("filt_valid", filter_valid, 1);
      check("filt_data", in_data, fmod[k]);
      check("filt_size", filter_size, fs);
      check("filt_pad", pad_mode, pad);
      check("filt_act", act_mode, act);
      check("filt_imgv", image_valid, 0);
      check("filt_imgsz", image_size, 0);
      check("filt_busy", busy, 1);
      if (wr_busy) begin
        wr_en = 1'b1; wr_sel = k[0]; wr_addr = 7'(k); wr_data = 8'h5A;
      end
      step();
    end
    wr_en = 1'b0;
    check("gap_fv", filter_valid, 0);
    check("gap_iv", image_valid, 0);
    check("gap_data", in_data, 0);
    check("gap_modes", {filter_size, pad_mode, act_mode, image_size}, 0);
    step();
    for (int k = 0; k < ni; k++) begin
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_iv", image_valid, 0);
        check("rst_data", in_data, 0);
        check("rst_imgsz", image_size, 0);
        check("rst_busy", busy, 0);
        step();
        rst_n = 1'b1;
        conv_out_valid = 1'b0;
        step();
        check("rst_idle_busy", busy, 0);
        check("rst_idle_fv", filter_valid, 0);
        check("rst_no_done", done, 0);
        return;
      end
      check("img_valid", image_valid, 1);
      check("img_data", in_data, imod[k]);
      check("img_size", image_size, s);
      check("img_fv", filter_valid, 0);
      check("img_modes", {filter_size, pad_mode, act_mode}, 0);
      if (k == ni - 1) conv_out_valid = 1'b0;
      step();
    end
    check("wait_iv", image_valid, 0);
    check("wait_fv", filter_valid, 0);
  endtask

  // Engine silent: done + timeout exactly 20 cycles after WAIT_RES entry.
  task automatic expect_timeout();
    repeat (19) step();
    check("to_early_done", done, 0);
    step();
    check("to_done", done, 1);
    check("to_flag", timeout, 1);
    check("to_cnt", result_cnt, 0);
    check("to_busy", busy, 1);
    step();
    check("to_busy_drop", busy, 0);
    check("to_done_drop", done, 0);
    check("to_flag_drop", timeout, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 7'd0; wr_data = 8'd0; start = 1'b0;
    cfg_filter_size = 1'b0; cfg_image_size = 4'd0; cfg_pad_mode = 1'b0; cfg_act_mode = 1'b0;
    conv_out_valid = 1'b0;
    repeat (3) step();
    check("rst_busy0", busy, 0);
    check("rst_done0", done, 0);
    check("rst_timeout0", timeout, 0);
    check("rst_err0", err, 0);
    check("rst_cnt0", result_cnt, 0);
    check("rst_valids0", {filter_valid, image_valid}, 0);
    check("rst_data0", in_data, 0);
    check("rst_modes0", {filter_size, pad_mode, act_mode, image_size}, 0);
    rst_n = 1'b1;
    step();

    // 3x3 filter 1..9, 4x4 image 0..15, plus an out-of-range image write that must be dropped.
    for (int k = 0; k < 9; k++) begin fmod[k] = 8'(k + 1); write_buf(1'b0, k, fmod[k]); end
    for (int k = 0; k < 16; k++) begin imod[k] = 8'(k); write_buf(1'b1, k, imod[k]); end
    write_buf(1'b1, 67, 8'hEE);
    write_buf(1'b0, 25, 8'hEE);

    xfer(1'b0, 4'd4, 1'b0, 1'b0, 0, 0, -1, 0, 8'h00);
    repeat (4) step();
    conv_out_valid = 1'b1;
    repeat (16) step();
    conv_out_valid = 1'b0;
    check("col_cnt16", result_cnt, 16);
    check("col_not_done", done, 0);
    step();
    check("col_done", done, 1);
    check("col_timeout0", timeout, 0);
    check("col_busy", busy, 1);
    check("col_cnt_at_done", result_cnt, 16);
    step();
    check("col_busy_drop", busy, 0);
    check("col_cnt_held", result_cnt, 16);

    // Illegal image sizes are rejected with a one-cycle err.
    for (int t = 0; t < 2; t++) begin
      cfg_image_size = (t == 0) ? 4'd3 : 4'd9;
      start = 1'b1;
      step();
      start = 1'b0;
      check("rej_err", err, 1);
      check("rej_busy", busy, 0);
      check("rej_fv", filter_valid, 0);
      step();
      check("rej_err_pulse", err, 0);
      check("rej_nobeats", {filter_valid, image_valid}, 0);
      check("rej_cnt_kept", result_cnt, 16);
    end

    // 5x5, S=8, modes set, noise on conv_out_valid while sending, same-edge write at start.
    for (int k = 0; k < 25; k++) begin fmod[k] = 8'(k * 7 - 50); write_buf(1'b0, k, fmod[k]); end
    for (int k = 0; k < 64; k++) begin imod[k] = 8'(200 - k * 3); write_buf(1'b1, k, imod[k]); end
    xfer(1'b1, 4'd8, 1'b1, 1'b1, 1, 0, -1, 1, 8'h81);
    expect_timeout();

    // Abort by reset mid-image, replay with writes attempted while busy, then replay again.
    xfer(1'b0, 4'd4, 1'b0, 1'b0, 0, 0, 5, 0, 8'h00);
    xfer(1'b0, 4'd4, 1'b0, 1'b0, 0, 1, -1, 0, 8'h00);
    expect_timeout();
    xfer(1'b0, 4'd4, 1'b0, 1'b0, 0, 0, -1, 0, 8'h00);
    expect_timeout();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/conv_stream_tx.md
Name: conv_stream_tx

Overview:
Transmit-side sequencer for the convolution engine's serial input protocol.
- Holds one filter and one image in local register buffers, loaded through a simple write port.
- On `start`, drives `filter_valid`/`image_valid`, the mode fields and `in_data` exactly as the convolution engine consumes them.
- Then watches the engine's `out_valid` stream, counts the results and signals completion.
- Sits between the host/test controller and the convolution engine.

Parameters:
- GAP_CYCLES, 1, idle cycles (both valids low) between the last filter beat and the first image beat; legal range 0..15.
- TIMEOUT_CYCLES, 1024, cycles allowed in WAIT_RES for the first result before aborting with `timeout`.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  buffer write strobe; ignored while `busy`=1.
- wr_sel  in  1  0 = filter buffer, 1 = image buffer.
- wr_addr  in  7  row-major index; filter 0..24, image 0..63; out-of-range writes are dropped.
- wr_data  in  8  signed sample/coefficient.
- start  in  1  one-cycle request; sampled only in IDLE.
- cfg_filter_size  in  1  0 = 3x3 (9 coefficients), 1 = 5x5 (25 coefficients).
- cfg_image_size  in  4  image edge length; legal range 4..8.
- cfg_pad_mode  in  1  passed through to `pad_mode`.
- cfg_act_mode  in  1  passed through to `act_mode`.
- busy  out  1  high from the cycle after `start` is accepted until `done`, inclusive.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  valid with `done`; 1 = no result seen within TIMEOUT_CYCLES.
- err  out  1  one-cycle pulse when `start` is rejected.
- result_cnt  out  7  number of `conv_out_valid` beats counted; held until the next accepted `start`.
- filter_valid  out  1  to engine.
- image_valid  out  1  to engine.
- filter_size  out  1  to engine.
- image_size  out  4  to engine.
- pad_mode  out  1  to engine.
- act_mode  out  1  to engine.
- in_data  out  8  signed, to engine.
- conv_out_valid  in  1  engine's `out_valid`.

Behaviour:
Reset:
- All outputs are 0; state is IDLE; buffers are not cleared.
- Reset asserted mid-operation aborts immediately: all engine-side outputs drop to 0 asynchronously, and no `done` pulse is issued.

Output timing and idle values:
- All outputs are registered.
- `in_data`, `filter_size`, `pad_mode`, `act_mode` and `image_size` are 0 whenever their associated valid is low.

States:
- IDLE
  - `start` with `cfg_image_size` < 4 or > 8 gives an `err` pulse on the next cycle and the state stays IDLE.
  - Otherwise the configuration is latched, `result_cnt` is cleared, and the state goes to SEND_FILT.
- SEND_FILT
  - First `filter_valid` appears the cycle after `start` (`start` at cycle N → first beat at N+1).
  - Lasts F = 9 or 25 consecutive cycles; `in_data` = filter[k], k = 0..F-1.
  - `filter_size`, `pad_mode` and `act_mode` are driven with the latched configuration on every beat.
  - Then goes to GAP, or directly to SEND_IMG if GAP_CYCLES = 0.
- GAP
  - GAP_CYCLES cycles with both valids low.
- SEND_IMG
  - S² consecutive cycles (S = latched image size); `in_data` = image[k], k = 0..S²-1.
  - `image_size` = S on every beat.
  - Then goes to WAIT_RES.
- WAIT_RES
  - Wait counter starts at 0 on entry.
  - `conv_out_valid` = 1 → go to COLLECT and count that beat.
  - When the counter reaches TIMEOUT_CYCLES → go to DONE with `timeout` = 1.
- COLLECT
  - `result_cnt` is incremented on every cycle `conv_out_valid` = 1, saturating at 127.
  - The first cycle with `conv_out_valid` = 0 → go to DONE.
- DONE
  - Single cycle: `done` = 1, `busy` still 1.
  - Next cycle: state IDLE, `busy` = 0.

Boundary conditions:
- `conv_out_valid` during SEND_FILT, GAP or SEND_IMG is ignored and not counted.
- `start` while `busy` = 1 is ignored (no `err`).
- A write at the same edge as an accepted `start` is performed; the transfer uses the updated buffer.

Test Plan:
- Filter 3x3 = 1..9, image 4x4 = 0..15, GAP = 1, `start` at cycle 10:
  - `filter_valid` at cycles 11..19 with `in_data` 1..9.
  - Both valids low at cycle 20.
  - `image_valid` at cycles 21..36 with `in_data` 0..15 and `image_size` = 4.
- Same transfer, engine model raises `conv_out_valid` for 16 cycles starting 5 cycles after the last image beat:
  - `result_cnt` = 16.
  - `done` = 1 one cycle after `conv_out_valid` falls; `timeout` = 0; `busy` drops on the next cycle.
- 5x5 filter, S = 8, `pad_mode` = 1, `act_mode` = 1:
  - 25 filter beats carrying `filter_size` = 1, `pad_mode` = 1, `act_mode` = 1.
  - 64 image beats carrying `image_size` = 8.
  - Mode outputs are 0 outside their valid beats.
- `cfg_image_size` = 3, then 9:
  - `err` pulse each time, `busy` stays 0, no valid beats.
- TIMEOUT_CYCLES = 20 with the engine silent:
  - `done` = 1 and `timeout` = 1 exactly 20 cycles after WAIT_RES entry; `result_cnt` = 0.
- Reset mid-SEND_IMG, then a `start` pulse with writes attempted during `busy`:
  - After reset, `image_valid` = 0 immediately and the state is IDLE.
  - A new `start` replays the buffers unchanged; writes attempted during `busy` are ignored.
